// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop produce {o_co, o_sum} = i_a + i_b + i_ci
// over WIDTH RUN cycles, bracketed by a start/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_co
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_shift_a;
  logic [WIDTH-1:0] r_shift_b;
  logic             r_carry;
  logic [CntW-1:0]  r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;

  state_e           w_state_d;
  logic [WIDTH-1:0] w_shift_a_d;
  logic [WIDTH-1:0] w_shift_b_d;
  logic             w_carry_d;
  logic [CntW-1:0]  w_count_d;
  logic [WIDTH-1:0] w_sum_d;
  logic             w_co_d;

  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH:0]   w_sum_cat;

  // Single full-adder cell shared by every bit position.
  assign w_fa_s = r_shift_a[0] ^ r_shift_b[0] ^ r_carry;
  assign w_fa_c = (r_shift_a[0] & r_shift_b[0]) | (r_carry & (r_shift_a[0] ^ r_shift_b[0]));

  // New bit enters at the MSB; after WIDTH shifts the LSB sum bit lands at position 0.
  assign w_sum_cat = {w_fa_s, r_sum};

  always_comb begin
    w_state_d   = r_state;
    w_shift_a_d = r_shift_a;
    w_shift_b_d = r_shift_b;
    w_carry_d   = r_carry;
    w_count_d   = r_count;
    w_sum_d     = r_sum;
    w_co_d      = r_co;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_shift_a_d = i_a;
          w_shift_b_d = i_b;
          w_carry_d   = i_ci;
          w_count_d   = '0;
          w_sum_d     = '0;
          w_co_d      = 1'b0;
          w_state_d   = StRun;
        end
      end
      StRun: begin
        w_shift_a_d = r_shift_a >> 1;
        w_shift_b_d = r_shift_b >> 1;
        w_sum_d     = w_sum_cat[WIDTH:1];
        w_carry_d   = w_fa_c;
        w_count_d   = r_count + CntW'(1);
        if (r_count == LastCnt) begin
          w_co_d    = w_fa_c;
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_shift_a <= '0;
      r_shift_b <= '0;
      r_carry   <= 1'b0;
      r_count   <= '0;
      r_sum     <= '0;
      r_co      <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_shift_a <= w_shift_a_d;
      r_shift_b <= w_shift_b_d;
      r_carry   <= w_carry_d;
      r_count   <= w_count_d;
      r_sum     <= w_sum_d;
      r_co      <= w_co_d;
    end
  end

  assign o_busy = (r_state == StRun);
  assign o_done = (r_state == StDone);
  assign o_sum  = r_sum;
  assign o_co   = r_co;

endmodule
